vgachargen_text_writer: RTL and testbench

VGACHARGEN_TEXT_WRITER -- requirements
Module: vgachargen_text_writer

---
 rtl/vgachargen_pkg.sv | 30 +++
 rtl/vgachargen_cursor.sv | 57 +++++
 rtl/vgachargen_text_writer.sv | 189 ++++++++++++++++++
 tb/tb_vgachargen_text_writer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vgachargen_pkg.sv
// vgachargen_pkg: shared FSM states, control codes and default text geometry.
// The CLEAR state exists only when VGACHARGEN_TEXT_WRITER_CLEAR_EN is defined.
package vgachargen_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;

    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] SPACE = 8'h20;

`ifdef VGACHARGEN_TEXT_WRITER_CLEAR_EN
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0
    } state_t;
`endif

    // Bytes that land in the character map as glyphs.
    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

endpackage

// File: rtl/vgachargen_cursor.sv
// vgachargen_cursor: text cursor x/y counters with end-of-row and end-of-screen wrap.
// No scrolling: stepping past the last row returns to row 0.
module vgachargen_cursor
    import vgachargen_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       advance,
    input  logic       line_feed,
    input  logic       carriage_return,
    input  logic       backspace,
    input  logic       home,
    output logic [6:0] x,
    output logic [4:0] y
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic [4:0] y_next_row;

    // Row below the current one, wrapping from the bottom row back to the top.
    always_comb begin
        y_next_row = (y == LAST_ROW) ? 5'd0 : y + 5'd1;
    end

    // Cursor update; home wins so a finished clear sweep always lands at (0,0).
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            x <= 7'd0;
            y <= 5'd0;
        end else if (home) begin
            x <= 7'd0;
            y <= 5'd0;
        end else if (advance) begin
            if (x == LAST_COL) begin
                x <= 7'd0;
                y <= y_next_row;
            end else begin
                x <= x + 7'd1;
            end
        end else if (line_feed) begin
            x <= 7'd0;
            y <= y_next_row;
        end else if (carriage_return) begin
            x <= 7'd0;
        end else if (backspace) begin
            if (x != 7'd0) begin
                x <= x - 7'd1;
            end
        end
    end

endmodule

// File: rtl/vgachargen_text_writer.sv
// vgachargen_text_writer: turns an ASCII byte stream into character/colour map writes.
// Define VGACHARGEN_TEXT_WRITER_CLEAR_EN to make form feed sweep the screen with spaces.
module vgachargen_text_writer
    import vgachargen_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        char_valid_i,
    input  logic [7:0]  char_data_i,
    output logic        char_ready_o,
    input  logic [7:0]  col_scheme_i,
    output logic [9:0]  char_map_addr_o,
    output logic        char_map_we_o,
    output logic [3:0]  char_map_be_o,
    output logic [31:0] char_map_wdata_o,
    output logic [9:0]  col_map_addr_o,
    output logic        col_map_we_o,
    output logic [3:0]  col_map_be_o,
    output logic [31:0] col_map_wdata_o,
    output logic [6:0]  cursor_x_o,
    output logic [4:0]  cursor_y_o,
    output logic        busy_o
);

    localparam int          WORDS  = COLS * ROWS / 4;
    localparam logic [11:0] COLS_W = 12'(COLS);

    state_t      state_q;
    state_t      state_d;
    logic        ready_q;
    logic        accept;
    logic        advance;
    logic        line_feed;
    logic        carriage_return;
    logic        backspace;
    logic        home;
    logic        write_cell;
    logic [11:0] cell_index;

`ifdef VGACHARGEN_TEXT_WRITER_CLEAR_EN
    localparam logic [9:0] LAST_WORD = 10'(WORDS - 1);

    logic        start_clear;
    logic        write_sweep;
    logic [9:0]  sweep_q;
    logic [7:0]  clear_scheme_q;
`endif

    assign char_ready_o = ready_q && (state_q == IDLE);
    assign accept       = char_valid_i && char_ready_o;
    assign cell_index   = {7'd0, cursor_y_o} * COLS_W + {5'd0, cursor_x_o};

`ifdef VGACHARGEN_TEXT_WRITER_CLEAR_EN
    assign busy_o = (state_q == CLEAR);
`else
    assign busy_o = 1'b0;
`endif

    vgachargen_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk             (clk_i),
        .arstn           (arstn_i),
        .advance         (advance),
        .line_feed       (line_feed),
        .carriage_return (carriage_return),
        .backspace       (backspace),
        .home            (home),
        .x               (cursor_x_o),
        .y               (cursor_y_o)
    );

    // Decode the accepted byte into a cursor command or write, and pick the next state.
    always_comb begin
        state_d         = state_q;
        advance         = 1'b0;
        line_feed       = 1'b0;
        carriage_return = 1'b0;
        backspace       = 1'b0;
        home            = 1'b0;
        write_cell      = 1'b0;
`ifdef VGACHARGEN_TEXT_WRITER_CLEAR_EN
        start_clear     = 1'b0;
        write_sweep     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_printable(char_data_i)) begin
                        write_cell = 1'b1;
                        advance    = 1'b1;
                    end else if (char_data_i == LF) begin
                        line_feed = 1'b1;
                    end else if (char_data_i == CR) begin
                        carriage_return = 1'b1;
                    end else if (char_data_i == BS) begin
                        backspace = 1'b1;
                    end
`ifdef VGACHARGEN_TEXT_WRITER_CLEAR_EN
                    else if (char_data_i == FF) begin
                        start_clear = 1'b1;
                        state_d     = CLEAR;
                    end
`endif
                end
            end
`ifdef VGACHARGEN_TEXT_WRITER_CLEAR_EN
            CLEAR: begin
                write_sweep = 1'b1;
                if (sweep_q == LAST_WORD) begin
                    home    = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State register; ready is held low during reset and rises on the first clock after.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
        end
    end

`ifdef VGACHARGEN_TEXT_WRITER_CLEAR_EN
    // Sweep word counter and the colour scheme captured with the form feed.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sweep_q        <= 10'd0;
            clear_scheme_q <= 8'd0;
        end else if (start_clear) begin
            sweep_q        <= 10'd0;
            clear_scheme_q <= col_scheme_i;
        end else if (write_sweep) begin
            sweep_q <= sweep_q + 10'd1;
        end
    end
`endif

    // Registered write ports: strobes pulse one cycle after the request, payload holds.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            char_map_addr_o  <= 10'd0;
            char_map_we_o    <= 1'b0;
            char_map_be_o    <= 4'd0;
            char_map_wdata_o <= 32'd0;
            col_map_addr_o   <= 10'd0;
            col_map_we_o     <= 1'b0;
            col_map_be_o     <= 4'd0;
            col_map_wdata_o  <= 32'd0;
        end else begin
            char_map_we_o <= 1'b0;
            col_map_we_o  <= 1'b0;
            if (write_cell) begin
                char_map_we_o    <= 1'b1;
                col_map_we_o     <= 1'b1;
                char_map_addr_o  <= cell_index[11:2];
                col_map_addr_o   <= cell_index[11:2];
                char_map_be_o    <= 4'b0001 << cell_index[1:0];
                col_map_be_o     <= 4'b0001 << cell_index[1:0];
                char_map_wdata_o <= {4{char_data_i}};
                col_map_wdata_o  <= {4{col_scheme_i}};
            end
`ifdef VGACHARGEN_TEXT_WRITER_CLEAR_EN
            else if (write_sweep) begin
                char_map_we_o    <= 1'b1;
                col_map_we_o     <= 1'b1;
                char_map_addr_o  <= sweep_q;
                col_map_addr_o   <= sweep_q;
                char_map_be_o    <= 4'hF;
                col_map_be_o     <= 4'hF;
                char_map_wdata_o <= {4{SPACE}};
                col_map_wdata_o  <= {4{clear_scheme_q}};
            end
`endif
        end
    end

endmodule

// File: tb/tb_vgachargen_text_writer.sv
// tb_vgachargen_text_writer: directed bench with a write scoreboard and cursor model.
// Clear-sweep checks are built only when VGACHARGEN_TEXT_WRITER_CLEAR_EN is defined.
module tb_vgachargen_text_writer;
    import vgachargen_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int WORDS = COLS * ROWS / 4;

    logic        clk_i        = 1'b0;
    logic        arstn_i      = 1'b0;
    logic        char_valid_i = 1'b0;
    logic [7:0]  char_data_i  = 8'd0;
    logic [7:0]  col_scheme_i = 8'd0;
    logic        char_ready_o;
    logic [9:0]  char_map_addr_o;
    logic        char_map_we_o;
    logic [3:0]  char_map_be_o;
    logic [31:0] char_map_wdata_o;
    logic [9:0]  col_map_addr_o;
    logic        col_map_we_o;
    logic [3:0]  col_map_be_o;
    logic [31:0] col_map_wdata_o;
    logic [6:0]  cursor_x_o;
    logic [4:0]  cursor_y_o;
    logic        busy_o;

    typedef struct packed {
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] cdata;
        logic [31:0] coldata;
    } write_t;

    write_t      exp_q[$];
    int          check_count  = 0;
    int          pass_count   = 0;
    int          fail_count   = 0;
    int          write_count  = 0;
    int          stall_count  = 0;
    int          model_x      = 0;
    int          model_y      = 0;
    logic [9:0]  last_addr    = 10'd0;
    logic [3:0]  last_be      = 4'd0;
    logic [31:0] last_cdata   = 32'd0;
    logic [31:0] last_coldata = 32'd0;

    // Free-running system clock.
    always #5 clk_i = ~clk_i;

    vgachargen_text_writer #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .clk_i            (clk_i),
        .arstn_i          (arstn_i),
        .char_valid_i     (char_valid_i),
        .char_data_i      (char_data_i),
        .char_ready_o     (char_ready_o),
        .col_scheme_i     (col_scheme_i),
        .char_map_addr_o  (char_map_addr_o),
        .char_map_we_o    (char_map_we_o),
        .char_map_be_o    (char_map_be_o),
        .char_map_wdata_o (char_map_wdata_o),
        .col_map_addr_o   (col_map_addr_o),
        .col_map_we_o     (col_map_we_o),
        .col_map_be_o     (col_map_be_o),
        .col_map_wdata_o  (col_map_wdata_o),
        .cursor_x_o       (cursor_x_o),
        .cursor_y_o       (cursor_y_o),
        .busy_o           (busy_o)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_cursor(input string tag, input int ex, input int ey);
        check_output({tag, "_x"}, 32'(cursor_x_o), 32'(ex));
        check_output({tag, "_y"}, 32'(cursor_y_o), 32'(ey));
    endtask

    task automatic model_next_row();
        model_y = (model_y == ROWS - 1) ? 0 : model_y + 1;
    endtask

    // Drive one byte, record the write it should cause and step the cursor model.
    task automatic apply_stimulus(input logic [7:0] code, input logic [7:0] scheme);
        int     waited = 0;
        int     idx;
        write_t w;
        while (!char_ready_o && waited < 1000) begin
            @(posedge clk_i);
            #1;
            waited++;
        end
        if (waited != 0) stall_count++;
        if (waited >= 1000) check_output("ready_timeout", 32'(char_ready_o), 32'd1);
        char_valid_i = 1'b1;
        char_data_i  = code;
        col_scheme_i = scheme;
        @(posedge clk_i);
        if (code >= 8'h20 && code <= 8'h7E) begin
            idx       = model_y * COLS + model_x;
            w.addr    = 10'(idx / 4);
            w.be      = 4'(1 << (idx % 4));
            w.cdata   = {4{code}};
            w.coldata = {4{scheme}};
            exp_q.push_back(w);
            if (model_x == COLS - 1) begin
                model_x = 0;
                model_next_row();
            end else begin
                model_x++;
            end
        end else if (code == 8'h0A) begin
            model_x = 0;
            model_next_row();
        end else if (code == 8'h0D) begin
            model_x = 0;
        end else if (code == 8'h08) begin
            if (model_x > 0) model_x--;
        end
`ifdef VGACHARGEN_TEXT_WRITER_CLEAR_EN
        else if (code == 8'h0C) begin
            for (int k = 0; k < WORDS; k++) begin
                w.addr    = 10'(k);
                w.be      = 4'hF;
                w.cdata   = 32'h2020_2020;
                w.coldata = {4{scheme}};
                exp_q.push_back(w);
            end
            model_x = 0;
            model_y = 0;
        end
`endif
        #1;
        char_valid_i = 1'b0;
    endtask

    // Wait until every expected write has been seen, bounded.
    task automatic wait_drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(posedge clk_i);
            #1;
            waited++;
        end
        @(posedge clk_i);
        #1;
        if (waited >= 2000) check_output("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every strobe seen on the falling edge must match the queue head.
    always @(negedge clk_i) begin
        write_t w;
        if (arstn_i && (char_map_we_o || col_map_we_o)) begin
            write_count++;
            last_addr    = char_map_addr_o;
            last_be      = char_map_be_o;
            last_cdata   = char_map_wdata_o;
            last_coldata = col_map_wdata_o;
            check_output("col_we_follows_char_we", 32'(col_map_we_o), 32'(char_map_we_o));
            if (exp_q.size() == 0) begin
                check_output("unexpected_write", 32'(char_map_we_o | col_map_we_o), 32'd0);
            end else begin
                w = exp_q.pop_front();
                check_output("char_addr", 32'(char_map_addr_o), 32'(w.addr));
                check_output("char_be", 32'(char_map_be_o), 32'(w.be));
                check_output("char_wdata", char_map_wdata_o, w.cdata);
                check_output("col_addr", 32'(col_map_addr_o), 32'(w.addr));
                check_output("col_be", 32'(col_map_be_o), 32'(w.be));
                check_output("col_wdata", col_map_wdata_o, w.coldata);
            end
        end
    end

    // Hard stop if something wedges the directed sequence.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int base;
        int waited;
        int low_cycles;

        arstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_output("rst_ready", 32'(char_ready_o), 32'd0);
        check_output("rst_char_we", 32'(char_map_we_o), 32'd0);
        check_output("rst_col_we", 32'(col_map_we_o), 32'd0);
        check_output("rst_addr", 32'(char_map_addr_o), 32'd0);
        check_output("rst_be", 32'(char_map_be_o), 32'd0);
        check_output("rst_wdata", char_map_wdata_o, 32'd0);
        check_output("rst_col_wdata", col_map_wdata_o, 32'd0);
        check_output("rst_busy", 32'(busy_o), 32'd0);
        check_cursor("rst_cursor", 0, 0);
        @(negedge clk_i);
        arstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_output("ready_after_release", 32'(char_ready_o), 32'd1);

        // Single printable character.
        apply_stimulus(8'h41, 8'h1F);
        check_cursor("a_cursor", 1, 0);
        wait_drain();
        check_output("a_addr", 32'(last_addr), 32'd0);
        check_output("a_be", 32'(last_be), 32'b0001);
        check_output("a_wdata", last_cdata, 32'h4141_4141);
        check_output("a_col_wdata", last_coldata, 32'h1F1F_1F1F);

        // Back-to-back burst crossing the end of row 0.
        apply_stimulus(8'h0D, 8'h00);
        check_cursor("cr_cursor", 0, 0);
        base        = write_count;
        stall_count = 0;
        for (int i = 0; i < 81; i++) apply_stimulus(8'h42, 8'h2A);
        check_output("burst_no_stall", 32'(stall_count), 32'd0);
        check_cursor("burst_cursor", 1, 1);
        wait_drain();
        check_output("burst_writes", 32'(write_count - base), 32'd81);
        check_output("burst_last_addr", 32'(last_addr), 32'd20);
        check_output("burst_last_be", 32'(last_be), 32'b0001);

        // Walk to the bottom row, check row wrap by line feed, then the last cell.
        apply_stimulus(8'h0D, 8'h00);
        for (int i = 0; i < 28; i++) apply_stimulus(8'h0A, 8'h00);
        check_cursor("lf_bottom", 0, 29);
        apply_stimulus(8'h0A, 8'h00);
        check_cursor("lf_wrap", 0, 0);
        for (int i = 0; i < 29; i++) apply_stimulus(8'h0A, 8'h00);
        for (int i = 0; i < 79; i++) apply_stimulus(8'h79, 8'h33);
        check_cursor("last_col", 79, 29);
        apply_stimulus(8'h5A, 8'h44);
        check_cursor("screen_wrap", 0, 0);
        wait_drain();
        check_output("z_addr", 32'(last_addr), 32'd599);
        check_output("z_be", 32'(last_be), 32'b1000);

        // Control codes and an ignored byte.
        base = write_count;
        apply_stimulus(8'h61, 8'h05);
        check_cursor("trace_a", 1, 0);
        apply_stimulus(8'h62, 8'h05);
        check_cursor("trace_b", 2, 0);
        apply_stimulus(8'h08, 8'h05);
        check_cursor("trace_bs", 1, 0);
        apply_stimulus(8'h0D, 8'h05);
        check_cursor("trace_cr", 0, 0);
        apply_stimulus(8'h0A, 8'h05);
        check_cursor("trace_lf", 0, 1);
        apply_stimulus(8'h07, 8'h05);
        check_cursor("trace_bel", 0, 1);
        apply_stimulus(8'h08, 8'h05);
        check_cursor("bs_hold", 0, 1);
        wait_drain();
        check_output("trace_writes", 32'(write_count - base), 32'd2);

`ifdef VGACHARGEN_TEXT_WRITER_CLEAR_EN
        // Full clear sweep.
        apply_stimulus(8'h71, 8'h01);
        wait_drain();
        base = write_count;
        apply_stimulus(8'h0C, 8'h07);
        check_output("clear_busy", 32'(busy_o), 32'd1);
        low_cycles = 0;
        while (!char_ready_o && low_cycles < 1000) begin
            low_cycles++;
            @(posedge clk_i);
            #1;
        end
        check_output("clear_ready_low_cycles", 32'(low_cycles), 32'(WORDS));
        check_cursor("clear_cursor", 0, 0);
        wait_drain();
        check_output("clear_writes", 32'(write_count - base), 32'(WORDS));
        check_output("clear_last_addr", 32'(last_addr), 32'd599);
        check_output("clear_last_be", 32'(last_be), 32'hF);
        check_output("clear_last_wdata", last_cdata, 32'h2020_2020);
        check_output("clear_last_col", last_coldata, 32'h0707_0707);
        check_output("clear_busy_done", 32'(busy_o), 32'd0);

        // Reset in the middle of a sweep.
        base = write_count;
        apply_stimulus(8'h0C, 8'h09);
        waited = 0;
        while ((write_count - base) < 300 && waited < 1000) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        if (waited >= 1000) check_output("sweep_300_timeout", 32'(write_count - base), 32'd300);
`else
        // Form feed is an ordinary ignored byte in this build.
        apply_stimulus(8'h71, 8'h01);
        wait_drain();
        base = write_count;
        apply_stimulus(8'h0C, 8'h07);
        check_output("ff_ready", 32'(char_ready_o), 32'd1);
        check_output("ff_busy", 32'(busy_o), 32'd0);
        check_cursor("ff_cursor", 1, 1);
        repeat (5) @(posedge clk_i);
        #1;
        check_output("ff_no_writes", 32'(write_count - base), 32'd0);
        check_output("ff_ready_stays", 32'(char_ready_o), 32'd1);
        apply_stimulus(8'h72, 8'h01);
        @(negedge clk_i);
        #1;
`endif
        base = write_count;
        #2;
        arstn_i = 1'b0;
        #1;
        check_output("midrst_char_we", 32'(char_map_we_o), 32'd0);
        check_output("midrst_col_we", 32'(col_map_we_o), 32'd0);
        check_output("midrst_busy", 32'(busy_o), 32'd0);
        check_output("midrst_ready", 32'(char_ready_o), 32'd0);
        check_output("midrst_addr", 32'(char_map_addr_o), 32'd0);
        exp_q.delete();
        model_x = 0;
        model_y = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        arstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_output("midrst_ready_after", 32'(char_ready_o), 32'd1);
        check_cursor("midrst_cursor", 0, 0);
        repeat (20) @(posedge clk_i);
        #1;
        check_output("midrst_no_writes", 32'(write_count - base), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
